lcd_bus_receiver: RTL and testbench

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_rx_pkg.sv | 53 +++++
 rtl/lcd_rx_sync.sv | 36 +++
 rtl/lcd_bus_receiver.sv | 181 ++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rx_pkg.sv
// Shared constants, state enumeration and bus payload for the HD44780 bus receiver.
// The optional busy-flag emulation is enabled by defining LCD_RX_BUSY_EN.
package lcd_rx_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned AC_W      = 7;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned BUF_DEPTH = 32;

    localparam logic [DATA_W-1:0] CMD_CLEAR      = 8'h01;
    localparam logic [DATA_W-1:0] CMD_HOME       = 8'h02;
    localparam logic [DATA_W-1:0] CMD_HOME_MASK  = 8'hFE;
    localparam logic [DATA_W-1:0] CMD_ENTRY      = 8'h04;
    localparam logic [DATA_W-1:0] CMD_ENTRY_MASK = 8'hFC;
    localparam logic [DATA_W-1:0] CMD_DDRAM      = 8'h80;
    localparam logic [DATA_W-1:0] CMD_DDRAM_MASK = 8'h80;

    localparam logic [AC_W-1:0] AC_LINE0_START = 7'h00;
    localparam logic [AC_W-1:0] AC_LINE0_END   = 7'h27;
    localparam logic [AC_W-1:0] AC_LINE1_START = 7'h40;
    localparam logic [AC_W-1:0] AC_LINE1_END   = 7'h67;

    localparam logic [DATA_W-1:0] SPACE    = 8'h20;
    localparam logic [IDX_W-1:0]  IDX_LAST = 5'd31;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic              en;
        logic              rs;
        logic              rw;
        logic [DATA_W-1:0] d;
    } lcd_bus_t;

    // DDRAM address step with the two-line wrap (0x27 <-> 0x40, 0x67 <-> 0x00)
    function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] a, input logic inc);
        logic [AC_W-1:0] r;
        if (inc) begin
            if (a == AC_LINE0_END)      r = AC_LINE1_START;
            else if (a == AC_LINE1_END) r = AC_LINE0_START;
            else                        r = AC_W'(a + AC_W'(1));
        end else begin
            if (a == AC_LINE1_START)      r = AC_LINE0_END;
            else if (a == AC_LINE0_START) r = AC_LINE1_END;
            else                          r = AC_W'(a - AC_W'(1));
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_rx_sync.sv
// Two-flop synchronizer for the LCD bus plus EN falling-edge write-strobe detector.
module lcd_rx_sync
    import lcd_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rs,
    input  logic              rw,
    input  logic [DATA_W-1:0] d,
    output lcd_bus_t          bus,
    output logic              wr_strobe_c
);

    lcd_bus_t meta_q;
    lcd_bus_t bus_q;
    logic     en_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q    <= '0;
            bus_q     <= '0;
            en_prev_q <= 1'b0;
        end else begin
            meta_q    <= '{en: en, rs: rs, rw: rw, d: d};
            bus_q     <= meta_q;
            en_prev_q <= bus_q.en;
        end
    end

    assign bus = bus_q;

    // RS and D come from bus_q, the same stage whose EN just fell
    assign wr_strobe_c = en_prev_q & ~bus_q.en & ~bus_q.rw;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Snoops an HD44780 write bus and mirrors the 2x16 visible characters into a buffer.
// Define LCD_RX_BUSY_EN to add busy-flag emulation (lcd_busy / lcd_q / lcd_q_oe).
module lcd_bus_receiver
    import lcd_rx_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic              clock_50MHz,
    input  logic              rst,
    input  logic [DATA_W-1:0] LCD_D,
    input  logic              LCD_EN,
    input  logic              LCD_RS,
    input  logic              LCD_RW,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_char,
    output logic [AC_W-1:0]   ac,
    output logic              clearing,
    output logic              strobe_err,
    output logic              lcd_busy,
    output logic [DATA_W-1:0] lcd_q,
    output logic              lcd_q_oe
);

    lcd_bus_t sync_bus;
    logic     wr_strobe_c;

    lcd_rx_sync u_sync (
        .clk         (clock_50MHz),
        .rst         (rst),
        .en          (LCD_EN),
        .rs          (LCD_RS),
        .rw          (LCD_RW),
        .d           (LCD_D),
        .bus         (sync_bus),
        .wr_strobe_c (wr_strobe_c)
    );

    state_t            state;
    state_t            state_next;
    logic              dir_inc;
    logic              dir_next;
    logic [AC_W-1:0]   ac_next;
    logic [IDX_W-1:0]  clr_idx;
    logic [IDX_W-1:0]  clr_idx_next;
    logic              err_next;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic              accept;
    logic              long_busy;
    logic              busy_now;
    logic [DATA_W-1:0] buffer [BUF_DEPTH];

    // State register: reset parks in CLEAR so the first released clock starts the fill
    always_ff @(posedge clock_50MHz) begin
        if (!rst) state <= ST_CLEAR;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (wr_strobe_c && !sync_bus.rs && sync_bus.d == CMD_CLEAR) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_idx == IDX_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command / data decode and buffer write port
    always_comb begin
        ac_next      = ac;
        dir_next     = dir_inc;
        clr_idx_next = clr_idx;
        err_next     = strobe_err;
        mem_we       = 1'b0;
        mem_idx      = clr_idx;
        mem_wdata    = SPACE;
        accept       = 1'b0;
        long_busy    = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                clr_idx_next = IDX_W'(clr_idx + IDX_W'(1));
                if (wr_strobe_c) err_next = 1'b1;
            end
            default: begin
                if (wr_strobe_c) begin
                    accept = 1'b1;
                    if (busy_now) err_next = 1'b1;
                    if (sync_bus.rs) begin
                        mem_we    = (ac[5:4] == 2'b00);
                        mem_idx   = {ac[6], ac[3:0]};
                        mem_wdata = sync_bus.d;
                        ac_next   = ac_step(ac, dir_inc);
                    end else if ((sync_bus.d & CMD_DDRAM_MASK) == CMD_DDRAM) begin
                        ac_next = sync_bus.d[AC_W-1:0];
                    end else if ((sync_bus.d & CMD_ENTRY_MASK) == CMD_ENTRY) begin
                        dir_next = sync_bus.d[1];
                    end else if ((sync_bus.d & CMD_HOME_MASK) == CMD_HOME) begin
                        ac_next   = '0;
                        long_busy = 1'b1;
                    end else if (sync_bus.d == CMD_CLEAR) begin
                        ac_next      = '0;
                        dir_next     = 1'b1;
                        clr_idx_next = '0;
                        long_busy    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock_50MHz) begin
        if (!rst) begin
            ac         <= '0;
            dir_inc    <= 1'b1;
            clr_idx    <= '0;
            clearing   <= 1'b1;
            strobe_err <= 1'b0;
            rd_char    <= '0;
        end else begin
            ac         <= ac_next;
            dir_inc    <= dir_next;
            clr_idx    <= clr_idx_next;
            clearing   <= (state_next == ST_CLEAR);
            strobe_err <= err_next;
            rd_char    <= buffer[rd_addr];
        end
    end

    // Character RAM: read-before-write, so a same-cycle collision returns the old value
    always_ff @(posedge clock_50MHz) begin
        if (rst && mem_we) buffer[mem_idx] <= mem_wdata;
    end

`ifdef LCD_RX_BUSY_EN
    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] busy_cnt_next;
    logic             busy_next;

    always_comb begin
        busy_cnt_next = (busy_cnt != '0) ? CNT_W'(busy_cnt - CNT_W'(1)) : '0;
        if (accept) busy_cnt_next = long_busy ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
        busy_next = (busy_cnt_next != '0);
    end

    assign busy_now = lcd_busy;

    always_ff @(posedge clock_50MHz) begin
        if (!rst) begin
            busy_cnt <= '0;
            lcd_busy <= 1'b0;
            lcd_q    <= '0;
            lcd_q_oe <= 1'b0;
        end else begin
            busy_cnt <= busy_cnt_next;
            lcd_busy <= busy_next;
            lcd_q_oe <= sync_bus.en & sync_bus.rw;
            lcd_q    <= (sync_bus.en && sync_bus.rw) ? {busy_next, ac_next} : '0;
        end
    end
`else
    logic unused_cfg;

    assign busy_now   = 1'b0;
    assign lcd_busy   = 1'b0;
    assign lcd_q      = '0;
    assign lcd_q_oe   = 1'b0;
    assign unused_cfg = ^{accept, long_busy, sync_bus.en, sync_bus.rw,
                          (BUSY_CYCLES == 0), (CLEAR_CYCLES == 0)};
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: reset fill, DDRAM addressing/wrap, commands,
// strobes dropped during clear, and the busy-flag outputs.
module tb_lcd_bus_receiver;

`ifdef LCD_RX_BUSY_EN
    localparam logic BUSY_BUILD = 1'b1;
`else
    localparam logic BUSY_BUILD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] lcd_d;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       clearing;
    logic       strobe_err;
    logic       lcd_busy;
    logic [7:0] lcd_q;
    logic       lcd_q_oe;

    int errors = 0;
    int checks = 0;

    lcd_bus_receiver dut (
        .clock_50MHz (clk),
        .rst         (rst),
        .LCD_D       (lcd_d),
        .LCD_EN      (lcd_en),
        .LCD_RS      (lcd_rs),
        .LCD_RW      (lcd_rw),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .ac          (ac),
        .clearing    (clearing),
        .strobe_err  (strobe_err),
        .lcd_busy    (lcd_busy),
        .lcd_q       (lcd_q),
        .lcd_q_oe    (lcd_q_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic lcd_write(input logic rs, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_d = d; lcd_rs = rs; lcd_rw = 1'b0; lcd_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic read_char(input logic [4:0] idx, output logic [7:0] val);
        @(posedge clk); #1 rd_addr = idx;
        @(posedge clk);
        @(negedge clk);
        val = rd_char;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_char !== 8'h00) begin errors++; $display("FAIL rst_rd_char: got %h expected 00", rd_char); end
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL rst_ac: got %h expected 00", ac); end
        checks++; if (clearing !== 1'b1) begin errors++; $display("FAIL rst_clearing: got %b expected 1", clearing); end
        checks++; if (strobe_err !== 1'b0) begin errors++; $display("FAIL rst_strobe_err: got %b expected 0", strobe_err); end
        checks++; if ({lcd_busy, lcd_q, lcd_q_oe} !== 10'h0) begin errors++; $display("FAIL rst_busy_outs: got %b %h %b expected 0 00 0", lcd_busy, lcd_q, lcd_q_oe); end
        // release, then re-assert mid-fill: the fill must restart from index 0
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (clearing !== 1'b1) begin errors++; $display("FAIL rst_mid_clearing: got %b expected 1", clearing); end
        @(posedge clk); #1 rst = 1'b1;
        repeat (31) @(posedge clk);
        @(negedge clk);
        checks++; if (clearing !== 1'b1) begin errors++; $display("FAIL clear_clk32_busy: got %b expected 1", clearing); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (clearing !== 1'b0) begin errors++; $display("FAIL clear_clk33_done: got %b expected 0", clearing); end
        for (int i = 0; i < 32; i++) begin
            read_char(5'(i), v);
            checks++; if (v !== 8'h20) begin errors++; $display("FAIL fill_idx%0d: got %h expected 20", i, v); end
        end
    endtask

    task automatic test_ddram_write;
        logic [7:0] v;
        lcd_write(1'b0, 8'h80);
        lcd_write(1'b1, 8'h41);
        lcd_write(1'b1, 8'h42);
        @(negedge clk);
        checks++; if (ac !== 7'h02) begin errors++; $display("FAIL wr_ac: got %h expected 02", ac); end
        read_char(5'd0, v);
        checks++; if (v !== 8'h41) begin errors++; $display("FAIL wr_idx0: got %h expected 41", v); end
        read_char(5'd1, v);
        checks++; if (v !== 8'h42) begin errors++; $display("FAIL wr_idx1: got %h expected 42", v); end
        read_char(5'd2, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL wr_idx2: got %h expected 20", v); end
    endtask

    task automatic test_line_wrap;
        logic [7:0] v;
        lcd_write(1'b0, 8'hA7);
        @(negedge clk);
        checks++; if (ac !== 7'h27) begin errors++; $display("FAIL wrap_set_ac: got %h expected 27", ac); end
        lcd_write(1'b1, 8'h58);
        @(negedge clk);
        checks++; if (ac !== 7'h40) begin errors++; $display("FAIL wrap_inc_ac: got %h expected 40", ac); end
        lcd_write(1'b1, 8'h59);
        @(negedge clk);
        checks++; if (ac !== 7'h41) begin errors++; $display("FAIL wrap_ac_41: got %h expected 41", ac); end
        read_char(5'd16, v);
        checks++; if (v !== 8'h59) begin errors++; $display("FAIL wrap_idx16: got %h expected 59", v); end
        read_char(5'd7, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL wrap_hidden_idx7: got %h expected 20", v); end
    endtask

    task automatic test_decrement;
        logic [7:0] v;
        lcd_write(1'b0, 8'h04);
        lcd_write(1'b0, 8'hC0);
        lcd_write(1'b1, 8'h31);
        @(negedge clk);
        checks++; if (ac !== 7'h27) begin errors++; $display("FAIL dec_wrap_ac: got %h expected 27", ac); end
        read_char(5'd16, v);
        checks++; if (v !== 8'h31) begin errors++; $display("FAIL dec_idx16: got %h expected 31", v); end
        lcd_write(1'b0, 8'h80);
        lcd_write(1'b1, 8'h33);
        @(negedge clk);
        checks++; if (ac !== 7'h67) begin errors++; $display("FAIL dec_zero_wrap_ac: got %h expected 67", ac); end
        read_char(5'd0, v);
        checks++; if (v !== 8'h33) begin errors++; $display("FAIL dec_idx0: got %h expected 33", v); end
        // 0x07: increment with D[0] ignored; write at 0x67 is off-screen and wraps to 0
        lcd_write(1'b0, 8'h07);
        lcd_write(1'b1, 8'h34);
        @(negedge clk);
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL inc_67_wrap_ac: got %h expected 00", ac); end
        read_char(5'd7, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL inc_67_hidden: got %h expected 20", v); end
    endtask

    task automatic test_ignored_cmds;
        logic [7:0] v;
        lcd_write(1'b0, 8'h85);
        lcd_write(1'b0, 8'h3F);
        lcd_write(1'b0, 8'h0C);
        @(negedge clk);
        checks++; if (ac !== 7'h05) begin errors++; $display("FAIL ign_ac: got %h expected 05", ac); end
        // read cycle with RS=1 must not write
        @(posedge clk); #1;
        lcd_d = 8'h99; lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 lcd_rw = 1'b0;
        @(negedge clk);
        checks++; if (ac !== 7'h05) begin errors++; $display("FAIL rd_cycle_ac: got %h expected 05", ac); end
        read_char(5'd5, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL rd_cycle_idx5: got %h expected 20", v); end
        lcd_write(1'b0, 8'h03);
        @(negedge clk);
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL home3_ac: got %h expected 00", ac); end
        lcd_write(1'b1, 8'h35);
        @(negedge clk);
        checks++; if (ac !== 7'h01) begin errors++; $display("FAIL home_dir_ac: got %h expected 01", ac); end
        read_char(5'd0, v);
        checks++; if (v !== 8'h35) begin errors++; $display("FAIL home_idx0: got %h expected 35", v); end
        checks++; if (strobe_err !== BUSY_BUILD) begin errors++; $display("FAIL no_err_yet: got %b expected %b", strobe_err, BUSY_BUILD); end
    endtask

    task automatic test_clear_drop;
        logic [7:0] v;
        logic       done;
        lcd_write(1'b0, 8'h04);
        lcd_write(1'b0, 8'h01);
        @(negedge clk);
        checks++; if (clearing !== 1'b1) begin errors++; $display("FAIL clr_started: got %b expected 1", clearing); end
        lcd_write(1'b1, 8'h5A);
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (clearing === 1'b0) done = 1'b1;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_timeout: got clearing=%b expected 0 within 64 clocks", clearing); end
        checks++; if (strobe_err !== 1'b1) begin errors++; $display("FAIL clr_strobe_err: got %b expected 1", strobe_err); end
        checks++; if (ac !== 7'h00) begin errors++; $display("FAIL clr_ac: got %h expected 00", ac); end
        for (int i = 0; i < 32; i++) begin
            read_char(5'(i), v);
            checks++; if (v !== 8'h20) begin errors++; $display("FAIL clr_idx%0d: got %h expected 20", i, v); end
        end
        // clear forces increment even after a decrement entry mode
        lcd_write(1'b1, 8'h36);
        @(negedge clk);
        checks++; if (ac !== 7'h01) begin errors++; $display("FAIL clr_dir_ac: got %h expected 01", ac); end
        read_char(5'd0, v);
        checks++; if (v !== 8'h36) begin errors++; $display("FAIL clr_dir_idx0: got %h expected 36", v); end
    endtask

`ifdef LCD_RX_BUSY_EN
    task automatic test_busy_flag;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) @(posedge clk);
        lcd_write(1'b1, 8'h41);
        repeat (96) @(posedge clk);
        #1 lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (lcd_q !== 8'h81) begin errors++; $display("FAIL busy_q_early: got %h expected 81", lcd_q); end
        checks++; if (lcd_q_oe !== 1'b1) begin errors++; $display("FAIL busy_oe: got %b expected 1", lcd_q_oe); end
        @(posedge clk); #1 lcd_en = 1'b0;
        repeat (1950) @(posedge clk);
        #1 lcd_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (lcd_q !== 8'h01) begin errors++; $display("FAIL busy_q_late: got %h expected 01", lcd_q); end
        @(posedge clk); #1 lcd_en = 1'b0; lcd_rw = 1'b0;
    endtask
`else
    task automatic test_busy_flag;
        @(posedge clk); #1 lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if ({lcd_busy, lcd_q, lcd_q_oe} !== 10'h0) begin errors++; $display("FAIL busy_tied: got %b %h %b expected 0 00 0", lcd_busy, lcd_q, lcd_q_oe); end
        @(posedge clk); #1 lcd_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 lcd_rw = 1'b0;
        @(negedge clk);
        checks++; if (ac !== 7'h01) begin errors++; $display("FAIL busy_rd_ac: got %h expected 01", ac); end
    endtask
`endif

    initial begin
        rst = 1'b0; lcd_d = 8'h00; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; rd_addr = 5'd0;
        test_reset();
        test_ddram_write();
        test_line_wrap();
        test_decrement();
        test_ignored_cmds();
        test_clear_drop();
        test_busy_flag();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
